// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared widths, FSM states and clog2 helper for the SDRAM arbiter
package sdram_arb_pkg;
  localparam int ADDR_W_DEF = 24;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sdram_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester above the last winner with modulo-N wrap
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] last,
  output logic [N-1:0]  win,
  output logic [PW-1:0] idx,
  output logic          valid
);
  logic [PW-1:0] p;
  always_comb begin
    win = '0;
    idx = '0;
    p = '0;
    // descending scan so the nearest port after last overwrites the others
    for (int k = N; k >= 1; k--) begin
      p = PW'((int'(last) + k) % N);
      if (req[p]) begin
        win = '0;
        win[p] = 1'b1;
        idx = p;
      end
    end
    valid = |req;
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of the SDRAM controller request port, one transaction in flight
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORT      = 4,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [NPORT-1:0]         m_req,
  input  logic [NPORT-1:0]         m_rh_wl,
  input  logic [NPORT*ADDR_W-1:0]  m_addr,
  input  logic [NPORT*DATA_W-1:0]  m_data_w,
  output logic [NPORT-1:0]         m_ack,
  output logic [DATA_W-1:0]        m_data_r,
  output logic [NPORT-1:0]         m_data_r_en,
  output logic                     sdram_req,
  output logic                     sdram_rh_wl,
  output logic [ADDR_W-1:0]        sdram_addr,
  output logic [DATA_W-1:0]        sdram_data_w,
  input  logic                     sdram_ack,
  input  logic [DATA_W-1:0]        sdram_data_r,
  input  logic                     sdram_data_r_en,
  output logic [NPORT-1:0]         grant,
  output logic                     busy,
  output logic                     rd_timeout_err
);
  localparam int PW = clog2(NPORT);
  localparam int CW = clog2(RD_TIMEOUT + 1);
  state_t state;
  logic [PW-1:0] ptr, gidx, pick_idx;
  logic [NPORT-1:0] pick_win;
  logic pick_valid;
  logic [CW-1:0] cnt;
  rr_pick #(.N(NPORT), .PW(PW)) u_pick (
    .req   (m_req),
    .last  (ptr),
    .win   (pick_win),
    .idx   (pick_idx),
    .valid (pick_valid)
  );
  always_comb begin
    busy = state != IDLE;
    m_data_r = sdram_data_r;
    m_ack = state == ISSUE ? grant & {NPORT{sdram_ack}} : '0;
    m_data_r_en = (state == WAIT_RD || (state == ISSUE && sdram_rh_wl)) ? grant & {NPORT{sdram_data_r_en}} : '0;
  end
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      state <= IDLE;
      ptr <= PW'(NPORT - 1);
      gidx <= '0;
      cnt <= '0;
      grant <= '0;
      sdram_req <= 1'b0;
      sdram_rh_wl <= 1'b1;
      sdram_addr <= '0;
      sdram_data_w <= '0;
      rd_timeout_err <= 1'b0;
    end else
      case (state)
        IDLE:
          if (pick_valid) begin
            state <= ISSUE;
            grant <= pick_win;
            gidx <= pick_idx;
            sdram_req <= 1'b1;
            sdram_rh_wl <= m_rh_wl[pick_idx];
            sdram_addr <= m_addr[pick_idx*ADDR_W +: ADDR_W];
            sdram_data_w <= m_data_w[pick_idx*DATA_W +: DATA_W];
          end
        ISSUE:
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            // a read whose data arrives with the ack completes here
            if (sdram_rh_wl && !sdram_data_r_en) begin
              state <= WAIT_RD;
              cnt <= '0;
            end else begin
              state <= IDLE;
              grant <= '0;
              ptr <= gidx;
            end
          end
        WAIT_RD:
          if (sdram_data_r_en || cnt == CW'(RD_TIMEOUT - 1)) begin
            state <= IDLE;
            grant <= '0;
            ptr <= gidx;
            rd_timeout_err <= rd_timeout_err | !sdram_data_r_en;
          end else
            cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a transaction-level model
module tb_sdram_arbiter;
  localparam int NP = 4, AW = 24, DW = 16, TO = 8;
  logic clk = 1'b0;
  logic reset_l = 1'b1;
  logic [NP-1:0] m_req = '0, m_rh_wl = '0, m_ack, m_data_r_en, grant;
  logic [NP*AW-1:0] m_addr = '0;
  logic [NP*DW-1:0] m_data_w = '0;
  logic [DW-1:0] m_data_r, sdram_data_w, sdram_data_r = '0;
  logic [AW-1:0] sdram_addr;
  logic sdram_req, sdram_rh_wl, sdram_ack = 1'b0, sdram_data_r_en = 1'b0, busy, rd_timeout_err;
  int compared = 0, mismatched = 0;
  int own = -1, ptr = NP - 1, wcnt = 0, rd_cd = 0, nord = 0;
  bit acked = 0, rd = 0, err = 0;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_dw;
  logic [NP-1:0] eg, seen_ack = '0;

  sdram_arbiter #(.NPORT(NP), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)) dut (
    .clk(clk), .reset_l(reset_l), .m_req(m_req), .m_rh_wl(m_rh_wl), .m_addr(m_addr),
    .m_data_w(m_data_w), .m_ack(m_ack), .m_data_r(m_data_r), .m_data_r_en(m_data_r_en),
    .sdram_req(sdram_req), .sdram_rh_wl(sdram_rh_wl), .sdram_addr(sdram_addr),
    .sdram_data_w(sdram_data_w), .sdram_ack(sdram_ack), .sdram_data_r(sdram_data_r),
    .sdram_data_r_en(sdram_data_r_en), .grant(grant), .busy(busy), .rd_timeout_err(rd_timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [NP-1:0] r, input int p);
    for (int k = 1; k <= NP; k++)
      if (r[(p + k) % NP]) return (p + k) % NP;
    return -1;
  endfunction

  task automatic set_port(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m_rh_wl[i] = rw;
    m_addr[i*AW +: AW] = a;
    m_data_w[i*DW +: DW] = d;
  endtask

  // check the current cycle against the model, then advance the model and the clock
  task automatic tick();
    #1;
    eg = own >= 0 ? NP'(1 << own) : '0;
    chk("grant", grant, eg);
    chk("busy", busy, own >= 0);
    chk("sdram_req", sdram_req, own >= 0 && !acked);
    if (own >= 0 && !acked) begin
      chk("sdram_addr", sdram_addr, e_addr);
      chk("sdram_data_w", sdram_data_w, e_dw);
      chk("sdram_rh_wl", sdram_rh_wl, rd);
    end
    chk("m_ack", m_ack, (own >= 0 && !acked && sdram_ack) ? eg : '0);
    chk("m_data_r_en", m_data_r_en, (own >= 0 && rd && sdram_data_r_en) ? eg : '0);
    chk("m_data_r", m_data_r, sdram_data_r);
    chk("rd_timeout_err", rd_timeout_err, err);
    seen_ack = m_ack;
    if (own < 0) begin
      own = rr(m_req, ptr);
      if (own >= 0) begin
        acked = 0;
        rd = m_rh_wl[own];
        e_addr = m_addr[own*AW +: AW];
        e_dw = m_data_w[own*DW +: DW];
      end
    end else if (!acked) begin
      if (sdram_ack) begin
        if (!rd || sdram_data_r_en) begin ptr = own; own = -1; end
        else begin acked = 1; wcnt = 0; end
      end
    end else if (sdram_data_r_en) begin
      ptr = own; own = -1;
    end else begin
      wcnt++;
      if (wcnt == TO) begin err = 1; ptr = own; own = -1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_l = 1'b0;
    m_req = '0;
    sdram_ack = 1'b0;
    sdram_data_r_en = 1'b0;
    #1;
    chk("rst_sdram_req", sdram_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", rd_timeout_err, 0);
    chk("rst_rh_wl", sdram_rh_wl, 1);
    own = -1; ptr = NP - 1; acked = 0; rd = 0; err = 0; rd_cd = 0; seen_ack = '0;
    @(posedge clk);
    #1;
    reset_l = 1'b1;
  endtask

  initial begin
    #2;
    apply_reset();
    // single write on port 2, acked 3 cycles after sdram_req rises
    set_port(2, 1'b0, 24'h00ABCD, 16'h1234);
    m_req = 4'b0100;
    tick();
    chk("t1_req_rise", sdram_req, 1);
    chk("t1_addr", sdram_addr, 24'h00ABCD);
    chk("t1_data", sdram_data_w, 16'h1234);
    tick(); tick(); tick();
    sdram_ack = 1'b1;
    #1 chk("t1_ack", m_ack, 4'b0100);
    tick();
    sdram_ack = 1'b0;
    m_req = '0;
    chk("t1_busy_fall", busy, 0);
    chk("t1_ack_once", m_ack, 0);
    tick();
    // read on port 1, data 5 cycles after the ack
    set_port(1, 1'b1, 24'h000010, 16'h0);
    m_req = 4'b0010;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    m_req = '0;
    repeat (4) begin
      chk("t2_grant_hold", grant, 4'b0010);
      chk("t2_no_req", sdram_req, 0);
      tick();
    end
    sdram_data_r = 16'hBEEF;
    sdram_data_r_en = 1'b1;
    #1 chk("t2_rden", m_data_r_en, 4'b0010);
    chk("t2_rdata", m_data_r, 16'hBEEF);
    tick();
    sdram_data_r_en = 1'b0;
    chk("t2_idle", busy, 0);
    tick();
    // all ports writing continuously from reset: order 0,1,2,3,0,1
    apply_reset();
    for (int i = 0; i < NP; i++) set_port(i, 1'b0, AW'($urandom), DW'($urandom));
    nord = 0;
    repeat (14) begin
      m_req = 4'hF & ~seen_ack;
      sdram_ack = own >= 0 && !acked;
      tick();
      for (int i = 0; i < NP; i++)
        if (seen_ack[i]) begin
          if (nord < 6) chk("rr_order", i, nord % NP);
          nord++;
        end
    end
    chk("rr_count", nord >= 6, 1);
    m_req = '0;
    sdram_ack = 1'b0;
    tick();
    // read with data coincident with the ack
    set_port(3, 1'b1, 24'h000003, 16'h0);
    m_req = 4'b1000;
    tick();
    sdram_ack = 1'b1;
    sdram_data_r_en = 1'b1;
    sdram_data_r = 16'hCAFE;
    #1 chk("t4_ack", m_ack, 4'b1000);
    chk("t4_rden", m_data_r_en, 4'b1000);
    tick();
    sdram_ack = 1'b0;
    sdram_data_r_en = 1'b0;
    m_req = '0;
    chk("t4_idle", busy, 0);
    tick();
    // read never answered
    set_port(0, 1'b1, 24'h000055, 16'h0);
    m_req = 4'b0001;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    m_req = '0;
    repeat (8) begin
      chk("t5_err_early", rd_timeout_err, 0);
      tick();
    end
    chk("t5_err_set", rd_timeout_err, 1);
    chk("t5_idle", busy, 0);
    set_port(3, 1'b0, 24'h000777, 16'hAAAA);
    m_req = 4'b1000;
    tick();
    chk("t5_grant3", grant, 4'b1000);
    sdram_ack = 1'b1;
    #1 chk("t5_ack3", m_ack, 4'b1000);
    tick();
    sdram_ack = 1'b0;
    m_req = '0;
    tick();
    // reset while waiting for read data
    set_port(1, 1'b1, 24'h000020, 16'h0);
    m_req = 4'b0010;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    m_req = '0;
    tick();
    tick();
    #2;
    apply_reset();
    set_port(0, 1'b0, 24'h000100, 16'h0101);
    set_port(3, 1'b0, 24'h000300, 16'h0303);
    m_req = 4'b1001;
    tick();
    chk("t6_port0_first", grant, 4'b0001);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    m_req = '0;
    tick();
    // randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < NP; i++)
        if (m_req[i] && seen_ack[i]) m_req[i] = 1'b0;
        else if (!m_req[i] && n < 1950 && $urandom_range(0, 3) == 0) begin
          set_port(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
          m_req[i] = 1'b1;
        end
      sdram_ack = 1'b0;
      sdram_data_r_en = 1'b0;
      sdram_data_r = DW'($urandom);
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) sdram_data_r_en = 1'b1;
      end else if (own >= 0 && !acked) begin
        if ($urandom_range(0, 2) == 0) begin
          sdram_ack = 1'b1;
          if (rd) begin
            rd_cd = $urandom_range(0, 5);
            if (rd_cd == 0) sdram_data_r_en = 1'b1;
          end
        end
      end else if (own < 0) begin
        sdram_ack = $urandom_range(0, 7) == 0;
        sdram_data_r_en = $urandom_range(0, 7) == 0;
      end
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
